// File: rtl/eth_tx_byte_packer.sv
// eth_tx_byte_packer: packs a byte stream little-endian into 32-bit
// MAC TX words, truncates oversize frames, keeps frame/error counters.
//
// Ports:
//   clk_app_i, rst_clk_app_n     clock, async active-low reset
//   s_byte_*                     upstream byte stream (valid/ready)
//   tx_valid_o..tx_bytesel_o     packed word to MAC, tx_ready_i accepts
//   tx_status_i/_valid_i         per-frame MAC status report
//   cnt_clr_i                    synchronous clear of all counters
//   frame_cnt_o, oversize_cnt_o  frames handed to MAC, truncated frames
//   err_cnt_o, err_irq_o         error status count and pulse
//   last_status_o                most recent status
module eth_tx_byte_packer #(
  parameter int         MAX_BYTES = 1518,
  parameter logic [7:0] ERR_MASK  = 8'h3E
) (
  input  logic        clk_app_i,
  input  logic        rst_clk_app_n,
  input  logic        s_byte_valid,
  input  logic [7:0]  s_byte_data,
  input  logic        s_byte_last,
  output logic        s_byte_ready,
  output logic        tx_valid_o,
  output logic [31:0] tx_data_o,
  output logic        tx_start_o,
  output logic        tx_end_o,
  output logic [1:0]  tx_bytesel_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  tx_status_i,
  input  logic        tx_status_valid_i,
  input  logic        cnt_clr_i,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] oversize_cnt_o,
  output logic [15:0] err_cnt_o,
  output logic [7:0]  last_status_o,
  output logic        err_irq_o
);

  localparam int FB_W =
    (MAX_BYTES < 7) ? 3 : $clog2(MAX_BYTES + 1);
  localparam logic [FB_W-1:0] MAX_FB = FB_W'(MAX_BYTES);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]      state;
  logic [1:0]      pack_cnt;
  logic [23:0]     pack_buf;
  logic [FB_W-1:0] frame_bytes;
  logic [FB_W-1:0] byte_num;
  logic [31:0]     word_nxt;
  logic            in_drain;
  logic            accept;
  logic            take;
  logic            at_max;
  logic            closing;
  logic            complete;
  logic            first_word;
  logic            tx_fire;
  logic            err_hit;

  assign in_drain     = (state == DRAIN);
  assign s_byte_ready = in_drain | ~tx_valid_o | tx_ready_i;
  assign accept       = s_byte_valid & s_byte_ready;
  assign take         = accept & ~in_drain;
  assign byte_num     = frame_bytes + FB_W'(1);
  assign at_max       = (byte_num == MAX_FB);
  assign closing      = s_byte_last | at_max;
  assign complete     = (pack_cnt == 2'd3) | closing;
  // only the first word of a frame completes within bytes 1..4
  assign first_word   = (byte_num <= FB_W'(4));
  // held bytes above pack_cnt are zero, so OR-in places the new byte
  assign word_nxt     = {8'h00, pack_buf} |
                        ({24'h0, s_byte_data} << {pack_cnt, 3'b000});
  assign tx_fire      = tx_valid_o & tx_ready_i;
  assign err_hit      = tx_status_valid_i & |(tx_status_i & ERR_MASK);

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      state <= IDLE;
    end else if (accept) begin
      if (in_drain)
        state <= s_byte_last ? IDLE : DRAIN;
      else if (s_byte_last)
        state <= IDLE;
      else if (at_max)
        state <= DRAIN;
      else
        state <= FILL;
    end
  end

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      pack_cnt    <= 2'd0;
      pack_buf    <= 24'h0;
      frame_bytes <= '0;
    end else if (take) begin
      if (complete) begin
        pack_cnt    <= 2'd0;
        pack_buf    <= 24'h0;
        frame_bytes <= closing ? '0 : byte_num;
      end else begin
        pack_cnt    <= pack_cnt + 2'd1;
        pack_buf    <= word_nxt[23:0];
        frame_bytes <= byte_num;
      end
    end
  end

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      tx_valid_o   <= 1'b0;
      tx_data_o    <= 32'h0;
      tx_start_o   <= 1'b0;
      tx_end_o     <= 1'b0;
      tx_bytesel_o <= 2'd0;
    end else if (take && complete) begin
      tx_valid_o   <= 1'b1;
      tx_data_o    <= word_nxt;
      tx_start_o   <= first_word;
      tx_end_o     <= closing;
      tx_bytesel_o <= pack_cnt;
    end else if (tx_ready_i) begin
      tx_valid_o   <= 1'b0;
    end
  end

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      frame_cnt_o    <= 16'h0;
      oversize_cnt_o <= 16'h0;
      err_cnt_o      <= 16'h0;
    end else if (cnt_clr_i) begin
      frame_cnt_o    <= 16'h0;
      oversize_cnt_o <= 16'h0;
      err_cnt_o      <= 16'h0;
    end else begin
      if (tx_fire && tx_end_o)
        frame_cnt_o <= frame_cnt_o + 16'd1;
      if (take && at_max && !s_byte_last)
        oversize_cnt_o <= oversize_cnt_o + 16'd1;
      if (err_hit)
        err_cnt_o <= err_cnt_o + 16'd1;
    end
  end

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      last_status_o <= 8'h0;
      err_irq_o     <= 1'b0;
    end else begin
      if (tx_status_valid_i)
        last_status_o <= tx_status_i;
      err_irq_o <= err_hit;
    end
  end

endmodule

// File: tb/tb_eth_tx_byte_packer.sv
// tb_eth_tx_byte_packer: directed + randomized frames checked against
// a queue-based word model, plus counter/status/reset checks.
module tb_eth_tx_byte_packer;

  localparam int         MAX_BYTES = 1518;
  localparam logic [7:0] ERR_MASK  = 8'h3E;

  typedef logic [7:0] bq_t[$];

  logic        clk;
  logic        rst_n;
  logic        s_byte_valid;
  logic [7:0]  s_byte_data;
  logic        s_byte_last;
  logic        s_byte_ready;
  logic        tx_valid_o;
  logic [31:0] tx_data_o;
  logic        tx_start_o;
  logic        tx_end_o;
  logic [1:0]  tx_bytesel_o;
  logic        tx_ready_i;
  logic [7:0]  tx_status_i;
  logic        tx_status_valid_i;
  logic        cnt_clr_i;
  logic [15:0] frame_cnt_o;
  logic [15:0] oversize_cnt_o;
  logic [15:0] err_cnt_o;
  logic [7:0]  last_status_o;
  logic        err_irq_o;

  int n_checks = 0;
  int n_errs   = 0;

  logic [35:0] obs_q[$];
  logic [35:0] exp_q[$];
  logic [15:0] exp_frames = 0;
  logic [15:0] exp_over   = 0;
  logic [15:0] exp_err    = 0;
  bit          rdy_rand   = 0;
  bit          hold_v     = 0;
  logic [36:0] held;

  eth_tx_byte_packer #(
    .MAX_BYTES(MAX_BYTES),
    .ERR_MASK (ERR_MASK)
  ) dut (
    .clk_app_i        (clk),
    .rst_clk_app_n    (rst_n),
    .s_byte_valid     (s_byte_valid),
    .s_byte_data      (s_byte_data),
    .s_byte_last      (s_byte_last),
    .s_byte_ready     (s_byte_ready),
    .tx_valid_o       (tx_valid_o),
    .tx_data_o        (tx_data_o),
    .tx_start_o       (tx_start_o),
    .tx_end_o         (tx_end_o),
    .tx_bytesel_o     (tx_bytesel_o),
    .tx_ready_i       (tx_ready_i),
    .tx_status_i      (tx_status_i),
    .tx_status_valid_i(tx_status_valid_i),
    .cnt_clr_i        (cnt_clr_i),
    .frame_cnt_o      (frame_cnt_o),
    .oversize_cnt_o   (oversize_cnt_o),
    .err_cnt_o        (err_cnt_o),
    .last_status_o    (last_status_o),
    .err_irq_o        (err_irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // random backpressure, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    if (rdy_rand) tx_ready_i = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 0;
    end else begin
      if (hold_v)
        chk("hold_stable",
            {tx_valid_o, tx_start_o, tx_end_o, tx_bytesel_o, tx_data_o},
            held);
      if (tx_valid_o && tx_ready_i)
        obs_q.push_back({tx_start_o, tx_end_o, tx_bytesel_o, tx_data_o});
      hold_v = tx_valid_o && !tx_ready_i;
      held = {tx_valid_o, tx_start_o, tx_end_o, tx_bytesel_o, tx_data_o};
    end
  end

  function automatic void model_frame(input bq_t b);
    int n;
    int nw;
    int cnt;
    logic [31:0] d;
    n  = (b.size() > MAX_BYTES) ? MAX_BYTES : b.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      cnt = (w == nw - 1) ? n - 4 * w : 4;
      d = '0;
      for (int k = 0; k < cnt; k++) d[8*k +: 8] = b[4*w + k];
      exp_q.push_back({w == 0, w == nw - 1, 2'(cnt - 1), d});
    end
    exp_frames++;
    if (b.size() > MAX_BYTES) exp_over++;
  endfunction

  task automatic idle_garbage();
    s_byte_valid = 1'b0;
    s_byte_data  = 8'($urandom);
    s_byte_last  = 1'($urandom);
  endtask

  task automatic send_frame(input bq_t b, input bit gaps,
                            input bit close, output int waits);
    int t;
    waits = 0;
    @(posedge clk); #1;
    foreach (b[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        idle_garbage();
        @(posedge clk); #1;
      end
      s_byte_valid = 1'b1;
      s_byte_data  = b[i];
      s_byte_last  = close && (i == b.size() - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (s_byte_ready || t > 2000) break;
        waits++;
        t++;
      end
      if (!s_byte_ready) chk("byte_accept", s_byte_ready, 1'b1);
      @(posedge clk); #1;
    end
    idle_garbage();
  endtask

  task automatic wait_words();
    int t = 0;
    while (obs_q.size() < exp_q.size() && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic cmp_words(input string tag);
    chk({tag, "_nwords"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    chk({tag, "_frame_cnt"}, frame_cnt_o, exp_frames);
    chk({tag, "_oversize_cnt"}, oversize_cnt_o, exp_over);
  endtask

  task automatic send_status(input logic [7:0] s, input bit clr);
    bit hit;
    hit = |(s & ERR_MASK);
    @(posedge clk); #1;
    tx_status_i       = s;
    tx_status_valid_i = 1'b1;
    cnt_clr_i         = clr;
    @(posedge clk); #1;
    tx_status_valid_i = 1'b0;
    cnt_clr_i         = 1'b0;
    tx_status_i       = 8'($urandom);
    if (clr) begin
      exp_err = 0;
      exp_frames = 0;
      exp_over = 0;
    end else if (hit) begin
      exp_err++;
    end
    @(negedge clk);
    chk($sformatf("last_status_%h", s), last_status_o, s);
    chk($sformatf("err_cnt_%h", s), err_cnt_o, exp_err);
    chk($sformatf("irq_%h", s), err_irq_o, hit);
    chk("frame_cnt_after_status", frame_cnt_o, exp_frames);
    @(negedge clk);
    chk($sformatf("irq_drop_%h", s), err_irq_o, 1'b0);
  endtask

  initial begin
    bq_t f;
    int  w;
    rst_n             = 1'b0;
    tx_ready_i        = 1'b0;
    tx_status_i       = 8'h0;
    tx_status_valid_i = 1'b0;
    cnt_clr_i         = 1'b0;
    idle_garbage();

    #13;
    chk("rst_tx_valid", tx_valid_o, 1'b0);
    chk("rst_s_ready", s_byte_ready, 1'b1);
    chk("rst_tx_data", tx_data_o, 32'h0);
    chk("rst_flags", {tx_start_o, tx_end_o, tx_bytesel_o}, 4'h0);
    chk("rst_cnts", {frame_cnt_o, oversize_cnt_o, err_cnt_o}, 48'h0);
    chk("rst_status", {last_status_o, err_irq_o}, 9'h0);

    @(posedge clk); #1;
    rst_n      = 1'b1;
    tx_ready_i = 1'b1;

    // 6-byte frame at full rate
    f = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    model_frame(f);
    send_frame(f, 0, 1, w);
    chk("six_full_rate_waits", w, 0);
    wait_words();
    cmp_words("six");

    // single byte frame, latency 1
    f = {8'hAA};
    model_frame(f);
    send_frame(f, 0, 1, w);
    @(negedge clk);
    chk("one_latency_valid", tx_valid_o, 1'b1);
    chk("one_word", {tx_start_o, tx_end_o, tx_bytesel_o, tx_data_o},
        {1'b1, 1'b1, 2'd0, 32'h000000AA});
    wait_words();
    cmp_words("one");

    // 64-byte frame with a 10-cycle stall
    f.delete();
    for (int i = 0; i < 64; i++) f.push_back(8'($urandom));
    model_frame(f);
    fork
      send_frame(f, 0, 1, w);
      begin
        repeat (5) @(posedge clk);
        #1 tx_ready_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (tx_valid_o) chk("stall_s_ready", s_byte_ready, 1'b0);
          if (c == 9)
            chk("stall_valid_held", tx_valid_o, 1'b1);
          @(posedge clk); #1;
        end
        tx_ready_i = 1'b1;
      end
    join
    wait_words();
    chk("stall_nwords_16", exp_q.size() == 16 ? obs_q.size() : -1, 16);
    cmp_words("stall");

    // random frames, random gaps and backpressure
    rdy_rand = 1;
    for (int fr = 0; fr < 20; fr++) begin
      f.delete();
      for (int i = 0; i < $urandom_range(1, 40); i++)
        f.push_back(8'($urandom));
      model_frame(f);
      send_frame(f, 1, 1, w);
    end
    wait_words();
    cmp_words("rand");

    // oversize frame then a short frame
    f.delete();
    for (int i = 0; i < 2000; i++) f.push_back(8'($urandom));
    model_frame(f);
    send_frame(f, 0, 1, w);
    wait_words();
    chk("big_nwords", obs_q.size(), 380);
    if (obs_q.size() == 380)
      chk("big_last_flags", obs_q[379][34:32], 3'b101);
    chk("big_oversize", oversize_cnt_o, 16'd1);
    cmp_words("big");
    f = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    model_frame(f);
    send_frame(f, 1, 1, w);
    wait_words();
    cmp_words("after_big");
    rdy_rand = 0;
    @(posedge clk); #1 tx_ready_i = 1'b1;

    // status / error counting
    send_status(8'h04, 0);
    send_status(8'h01, 0);
    for (int i = 0; i < 6; i++) send_status(8'($urandom), 0);
    send_status(8'h08, 1);
    chk("clr_all", {frame_cnt_o, oversize_cnt_o, err_cnt_o}, 48'h0);

    // reset mid-frame
    f = {8'h91, 8'h92, 8'h93, 8'h94, 8'h95};
    send_frame(f, 0, 0, w);
    @(negedge clk);
    chk("pre_rst_frames", frame_cnt_o, exp_frames);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", tx_valid_o, 1'b0);
    chk("async_rst_ready", s_byte_ready, 1'b1);
    chk("async_rst_status", last_status_o, 8'h0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    exp_frames = 0;
    exp_over = 0;
    f = {8'hC1, 8'hC2, 8'hC3};
    model_frame(f);
    send_frame(f, 0, 1, w);
    wait_words();
    if (obs_q.size() == 1)
      chk("post_rst_word", obs_q[0], {1'b1, 1'b1, 2'd2, 32'h00C3C2C1});
    cmp_words("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
